// File: rtl/regfile_pkg.sv
// Shared widths, special register numbers and the queued-write entry type.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Producer/regfile/decode-facing signal bundle of the write buffer.
interface regfile_write_buffer_if
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_link;
  logic [DATA_W-1:0] in_link_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;

  logic [CNT_W-1:0]  count;
  logic              empty;

  // Environment side: producers, regfile write port and decode.
  modport master (
    output in_valid, in_addr, in_data, in_link, in_link_data, rd_addr1, rd_addr2,
    input  in_ready, wr_en, wr_addr, wr_data, byp_hit1, byp_hit2,
           byp_data1, byp_data2, count, empty
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_addr, in_data, in_link, in_link_data, rd_addr1, rd_addr2,
    output in_ready, wr_en, wr_addr, wr_data, byp_hit1, byp_hit2,
           byp_data1, byp_data2, count, empty
  );

endinterface

// File: rtl/regfile_write_buffer_wbuf_match.sv
// Youngest-first associative match over the write-buffer entries for one read port.
module wbuf_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wb_entry_t                  i_entries [DEPTH],
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [$clog2(DEPTH)-1:0]   i_tail,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  output logic                       o_hit,
  output logic [DATA_W-1:0]          o_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_slot;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match written wins.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_slot = '0;
    if (i_rd_addr != ZERO_REG) begin
      for (int unsigned k = DEPTH; k >= 1; k--) begin
        w_slot = i_tail - PTR_W'(k);
        if (i_valid[w_slot] && (i_entries[w_slot].addr == i_rd_addr)) begin
          o_hit  = 1'b1;
          o_data = i_entries[w_slot].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// Queues register writes (including JAL rd + r31 pairs) and drains one per clock
// into the regfile write port, with a youngest-entry bypass for both decode reads.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_buffer_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_push_rd;
  logic             w_push_lk;
  logic             w_pop;
  logic [CNT_W-1:0] w_npush;
  logic [PTR_W-1:0] w_lk_slot;
  logic [DEPTH-1:0] w_valid;
  wb_entry_t        w_head_entry;

  // Room for a worst-case two-entry push is required regardless of the request.
  assign bus.in_ready = (r_count <= CNT_W'(DEPTH - 2));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_push_rd    = w_accept && (bus.in_addr != ZERO_REG);
  assign w_push_lk    = w_accept && bus.in_link;
  assign w_npush      = CNT_W'(w_push_rd) + CNT_W'(w_push_lk);
  assign w_pop        = (r_count != '0);
  // The link entry lands right after the rd entry, or at tail when rd was r0.
  assign w_lk_slot    = r_tail + PTR_W'(w_push_rd);

  // Pointer and occupancy update; reset discards the queue asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_npush);
      r_count <= r_count + w_npush - CNT_W'(w_pop);
    end
  end

  // Entry storage; contents are only meaningful under the valid mask.
  always_ff @(posedge clk) begin
    if (w_push_rd) begin
      r_mem[r_tail] <= '{addr: bus.in_addr, data: bus.in_data};
    end
    if (w_push_lk) begin
      r_mem[w_lk_slot] <= '{addr: LINK_REG, data: bus.in_link_data};
    end
  end

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
    end
  end

  assign w_head_entry = r_mem[r_head];

  // Write port outputs are forced to zero when idle so stale storage never shows.
  assign bus.wr_en   = w_pop;
  assign bus.wr_addr = w_pop ? w_head_entry.addr : '0;
  assign bus.wr_data = w_pop ? w_head_entry.data : '0;
  assign bus.count   = r_count;
  assign bus.empty   = (r_count == '0);

  wbuf_match #(.DEPTH(DEPTH)) u_match1 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_tail    (r_tail),
    .i_rd_addr (bus.rd_addr1),
    .o_hit     (bus.byp_hit1),
    .o_data    (bus.byp_data1)
  );

  wbuf_match #(.DEPTH(DEPTH)) u_match2 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_tail    (r_tail),
    .i_rd_addr (bus.rd_addr2),
    .o_hit     (bus.byp_hit2),
    .o_data    (bus.byp_data2)
  );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench for regfile_write_buffer: every accepted request pushes its
// expected regfile writes; the monitor pops and compares on each wr_en cycle.
module tb_regfile_write_buffer;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;

  regfile_write_buffer_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_entry_t sb [$];
  int n_cmp = 0;
  int n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference bypass: the last matching queued entry is the youngest.
  function automatic void byp_model(input logic [ADDR_W-1:0] a, output logic hit,
                                    output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0) begin
      foreach (sb[i]) begin
        if (sb[i].addr == a) begin
          hit = 1'b1;
          d   = sb[i].data;
        end
      end
    end
  endfunction

  // Called just after an active edge, when the scoreboard equals the queue.
  task automatic check_state(input string tag);
    logic              h;
    logic [DATA_W-1:0] d;
    chk({tag, "_count"}, 64'(bus.count), 64'(sb.size()));
    chk({tag, "_empty"}, 64'(bus.empty), 64'(sb.size() == 0));
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'((int'(DEPTH) - sb.size()) >= 2));
    byp_model(bus.rd_addr1, h, d);
    chk({tag, "_hit1"}, 64'(bus.byp_hit1), 64'(h));
    chk({tag, "_bdata1"}, 64'(bus.byp_data1), 64'(d));
    byp_model(bus.rd_addr2, h, d);
    chk({tag, "_hit2"}, 64'(bus.byp_hit2), 64'(h));
    chk({tag, "_bdata2"}, 64'(bus.byp_data2), 64'(d));
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic l, input logic [DATA_W-1:0] ld);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid     = 1'b1;
    bus.in_addr      = a;
    bus.in_data      = d;
    bus.in_link      = l;
    bus.in_link_data = ld;
    if (a != 0) sb.push_back('{addr: a, data: d});
    if (l)      sb.push_back('{addr: LINK_REG, data: ld});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every regfile write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 64'(bus.wr_addr), 64'hFFFF_FFFF);
      end else begin
        wb_entry_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_addr      = '0;
    bus.in_data      = '0;
    bus.in_link      = 1'b0;
    bus.in_link_data = '0;
    bus.rd_addr1     = 5'd5;
    bus.rd_addr2     = 5'd31;
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_hit1", 64'(bus.byp_hit1), 64'd0);
    chk("rst_bdata2", 64'(bus.byp_data2), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single write: visible the cycle after acceptance, gone the cycle after.
    push(5'd5, 32'hDEADBEEF, 1'b0, '0);
    chk("single_wr_en", 64'(bus.wr_en), 64'd1);
    chk("single_wr_addr", 64'(bus.wr_addr), 64'd5);
    chk("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    check_state("single");
    @(posedge clk); #1;
    chk("single_idle_wr_en", 64'(bus.wr_en), 64'd0);
    chk("single_idle_empty", 64'(bus.empty), 64'd1);

    // JAL: r8 then r31 on consecutive cycles.
    push(5'd8, 32'h11, 1'b1, 32'h0040_0010);
    chk("jal_count_peak", 64'(bus.count), 64'd2);
    chk("jal_first_addr", 64'(bus.wr_addr), 64'd8);
    @(posedge clk); #1;
    chk("jal_second_addr", 64'(bus.wr_addr), 64'd31);
    chk("jal_second_data", 64'(bus.wr_data), 64'h0040_0010);
    @(posedge clk); #1;

    // r0 destination: handshake only, or only the link write.
    push(5'd0, 32'h1234, 1'b0, '0);
    chk("r0_count", 64'(bus.count), 64'd0);
    chk("r0_wr_en", 64'(bus.wr_en), 64'd0);
    push(5'd0, 32'h5678, 1'b1, 32'h0000_0ABC);
    chk("r0_link_count", 64'(bus.count), 64'd1);
    chk("r0_link_addr", 64'(bus.wr_addr), 64'd31);
    @(posedge clk); #1;

    // Bypass: two writes to r3 queued together, youngest wins; r0 never hits.
    bus.rd_addr1 = 5'd3;
    bus.rd_addr2 = 5'd0;
    push(5'd1, 32'h100, 1'b1, 32'h200);
    push(5'd3, 32'hA, 1'b0, '0);
    push(5'd3, 32'hB, 1'b0, '0);
    chk("byp_hit1", 64'(bus.byp_hit1), 64'd1);
    chk("byp_data1", 64'(bus.byp_data1), 64'hB);
    chk("byp_hit2", 64'(bus.byp_hit2), 64'd0);
    check_state("byp");
    repeat (3) @(posedge clk);
    #1;

    // Full boundary: count DEPTH-1 blocks input, one drain reopens it.
    push(5'd1, 32'h10, 1'b1, 32'h11);
    push(5'd2, 32'h20, 1'b1, 32'h21);
    chk("full_count", 64'(bus.count), 64'(DEPTH - 1));
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("drain1_ready", 64'(bus.in_ready), 64'd1);

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 60; i++) begin
      logic [ADDR_W-1:0] a;
      a = (i % 7 == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31));
      bus.rd_addr1 = ADDR_W'($urandom_range(0, 31));
      bus.rd_addr2 = (i % 2 == 0) ? 5'd31 : a;
      push(a, $urandom, 1'($urandom_range(0, 1)), $urandom);
      check_state("rand");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rand_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset with three entries queued.
    bus.rd_addr1 = 5'd4;
    push(5'd4, 32'h44, 1'b1, 32'h45);
    push(5'd6, 32'h66, 1'b1, 32'h67);
    chk("prerst_count", 64'(bus.count), 64'd3);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("async_rst_count", 64'(bus.count), 64'd0);
    chk("async_rst_hit1", 64'(bus.byp_hit1), 64'd0);
    chk("async_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
    end
    chk("post_rst_empty", 64'(bus.empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_buffer.md
# regfile_write_buffer

Write-side companion to the register file: queues pending register writes from producers (ALU result, load data, JAL link address), then drains them one per clock into the regfile's single write port (RegWrite/write/write_data). A JAL is split into two serialized writes: rd, then r31. A read-side bypass lets decode see a queued value before it reaches the array. Sits between execute/memory and `regfile`; `regfile` is only ever written through this block.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- DATA_W, 32, data width
- ADDR_W, 5, register address width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears queue
- in_valid  in  1  producer has a write request
- in_ready  out  1  buffer can accept a request this cycle
- in_addr  in  ADDR_W  destination register
- in_data  in  DATA_W  value for in_addr
- in_link  in  1  request also writes r31 (JAL)
- in_link_data  in  DATA_W  return address for r31
- wr_en  out  1  drives regfile RegWrite
- wr_addr  out  ADDR_W  drives regfile write
- wr_data  out  DATA_W  drives regfile write_data
- rd_addr1, rd_addr2  in  ADDR_W  decode read addresses
- byp_hit1, byp_hit2  out  1  a queued entry targets rd_addrN
- byp_data1, byp_data2  out  DATA_W  youngest queued value for rd_addrN
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH, plus an explicit count register.
- Accept = in_valid && in_ready; in_ready = (DEPTH − count) ≥ 2, independent of in_valid or payload.
- On accept, push in order:
  - (in_addr, in_data), skipped when in_addr == 0
  - (31, in_link_data), only when in_link
- Result: 0, 1 or 2 entries per accept. A write to r0 still completes the handshake; it enqueues nothing.
- Drain: wr_en = !empty; wr_addr/wr_data = head entry, combinational from storage. The head pops every cycle wr_en is high, because the regfile always accepts.
- Simultaneous push and pop in one cycle is legal. count_next = count + pushes − pop.
- Bypass: for each read port, search all valid entries and return the youngest one (nearest tail) whose addr matches.
  - rd_addrN == 0 never hits.
  - On a miss, byp_dataN = 0.
- The bypass reflects queue contents at the start of the cycle and does not include same-cycle in_* data.
- No entry is ever dropped or reordered.

## Timing
- Reset values: count 0, empty 1, in_ready 1, wr_en 0, wr_addr 0, wr_data 0, byp_hit1/2 0, byp_data1/2 0. Pointers 0; storage contents don't-care.
- Reset asserted mid-operation discards all queued entries immediately and asynchronously. No regfile write occurs while reset is high.
- Latency, empty queue: a request accepted at edge N appears on wr_* during cycle N+1. A JAL's r31 entry appears in cycle N+2.
- Throughput: one regfile write per cycle. Sustained JALs therefore back-pressure via in_ready.
- Full boundary: count == DEPTH−1 forces in_ready low, even for a request that would push 0 or 1 entries.
- Wrap: tail == DEPTH−1 followed by a two-entry push writes slots DEPTH−1 and 0.
- Outputs are combinational from registered state only; there are no in_* → out paths.

## Structure
- Shared package `regfile_pkg`: DATA_W, ADDR_W, LINK_REG = 5'd31, ZERO_REG = 5'd0, and a packed struct wb_entry_t {addr, data}.
- One sub-module, `wbuf_match`: a DEPTH-way youngest-first priority match (inputs: entries, valid mask, tail, rd_addr; outputs: hit, data). It is instantiated twice, once per read port.
- Storage and pointer logic stay in the top.

## Test plan
- Reset, then push (addr 5, 0xDEADBEEF) → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_en=0, empty=1.
- JAL push (addr 8, 0x11, link 0x00400010) → consecutive writes r8=0x11, then r31=0x00400010; count peaks at 2.
- Push addr 0 with in_link=0 → handshake completes, no wr_en pulse, count stays 0. Push addr 0 with in_link=1 → only the r31 write is emitted.
- Queue two writes to r3 (0xA, then 0xB) while rd_addr1=3 → byp_hit1=1, byp_data1=0xB. With rd_addr2=0 → byp_hit2=0.
- Fill until count=DEPTH−1 → in_ready=0. Drain one entry → in_ready=1. Continue pushes across the wrap point → wr_* sequence matches push order exactly.
- Assert reset asynchronously with 3 entries queued → wr_en and count drop to 0 before the next clock edge, and no stale write appears after release.
